spi_pattern_fsm: RTL and testbench

- Parametrised successor to the single-bit SPI state FSM.
- Consumes the serial bit stream from the SPI receiver as qualified bits (i_Data_en strobe) and shifts them into a PAT_W-bit window.
- Compares the window against a runtime pattern and mask, and reports a 4-state status, fill level and match pulse.
- Supports overlapping and non-overlapping detection modes.

---
 rtl/spi_pattern_fsm.sv | 145 ++++++++++++++
 tb/tb_spi_pattern_fsm.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_pattern_fsm.sv
// spi_pattern_fsm
//   Shifts qualified serial bits from the SPI receiver into a PAT_W-bit window.
//   After each accepted bit it compares the window against a runtime pattern
//   and mask, then reports the status, the fill level and a match pulse.
//
//   Optional feature: define SPI_PATTERN_MATCH_CNT_EN to build the saturating
//   match counter. When the macro is undefined, o_Match_cnt is tied to 0.
//
// Ports
//   i_Clk        clock
//   i_Rst        asynchronous reset, active-low
//   i_Clr        synchronous clear of window, fill, state and counter
//   i_Data_en    one-cycle qualifier for i_Data
//   i_Data       serial data bit
//   i_Pattern    expected pattern, MSB = oldest bit
//   i_Mask       1 = compare this bit, 0 = don't care
//   i_Mode       0 = overlapping, 1 = non-overlapping
//   o_State      0 IDLE, 1 FILL, 2 ARMED, 3 HIT
//   o_State_en   pulse: a bit was accepted
//   o_Fill       number of valid bits in the window, saturating at PAT_W
//   o_Window     shift register contents
//   o_Match      pulse coincident with o_State_en of the matching bit
//   o_Match_cnt  saturating match count
//
// State | meaning
// IDLE  | nothing accepted since reset/clear
// FILL  | window not yet full (or refilling after a non-overlapping hit)
// ARMED | window full, last accepted bit did not match
// HIT   | last accepted bit completed a match
module spi_pattern_fsm #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 16
) (
  input  logic                       i_Clk,
  input  logic                       i_Rst,
  input  logic                       i_Clr,
  input  logic                       i_Data_en,
  input  logic                       i_Data,
  input  logic [PAT_W-1:0]           i_Pattern,
  input  logic [PAT_W-1:0]           i_Mask,
  input  logic                       i_Mode,
  output logic [1:0]                 o_State,
  output logic                       o_State_en,
  output logic [$clog2(PAT_W+1)-1:0] o_Fill,
  output logic [PAT_W-1:0]           o_Window,
  output logic                       o_Match,
  output logic [CNT_W-1:0]           o_Match_cnt
);

  localparam int FW = $clog2(PAT_W+1);
  localparam logic [FW-1:0] FULL = FW'(PAT_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    ARMED = 2'd2,
    HIT   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [FW-1:0]     fill_q, fill_d;
  logic [PAT_W-1:0]  win_q, win_d;
  logic              state_en_q, state_en_d;
  logic              match_q, match_d;

  logic [PAT_W-1:0]  win_nx;
  logic [FW-1:0]     fill_nx;
  logic              hit_nx;

  always_comb begin
    win_nx  = {win_q[PAT_W-2:0], i_Data};
    fill_nx = (fill_q == FULL) ? FULL : fill_q + FW'(1);
    hit_nx  = (fill_nx == FULL) && (((win_nx ^ i_Pattern) & i_Mask) == '0);

    state_d    = state_q;
    fill_d     = fill_q;
    win_d      = win_q;
    state_en_d = 1'b0;
    match_d    = 1'b0;

    if (i_Clr) begin
      // Clear beats a simultaneous data strobe; the bit is dropped.
      state_d = IDLE;
      fill_d  = '0;
      win_d   = '0;
    end else if (i_Data_en) begin
      win_d      = win_nx;
      // A non-overlapping hit forces a full refill before the next match.
      fill_d     = (hit_nx && i_Mode) ? '0 : fill_nx;
      state_en_d = 1'b1;
      match_d    = hit_nx;
      case (state_q)
        IDLE:    state_d = FILL;
        FILL:    state_d = (fill_nx != FULL) ? FILL : (hit_nx ? HIT : ARMED);
        ARMED:   state_d = hit_nx ? HIT : ARMED;
        HIT:     state_d = i_Mode ? FILL : (hit_nx ? HIT : ARMED);
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state_q    <= IDLE;
      fill_q     <= '0;
      win_q      <= '0;
      state_en_q <= 1'b0;
      match_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_q     <= fill_d;
      win_q      <= win_d;
      state_en_q <= state_en_d;
      match_q    <= match_d;
    end
  end

  assign o_State    = state_q;
  assign o_State_en = state_en_q;
  assign o_Fill     = fill_q;
  assign o_Window   = win_q;
  assign o_Match    = match_q;

`ifdef SPI_PATTERN_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_Clr)
      cnt_d = '0;
    else if (i_Data_en && hit_nx && !(&cnt_q))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign o_Match_cnt = cnt_q;
`else
  assign o_Match_cnt = '0;
`endif

endmodule

// File: tb/tb_spi_pattern_fsm.sv
module tb_spi_pattern_fsm;

  localparam int PAT_W = 4;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clr;
  logic             data_en;
  logic             data;
  logic [PAT_W-1:0] pattern;
  logic [PAT_W-1:0] mask;
  logic             mode;
  logic [1:0]       state;
  logic             state_en;
  logic [2:0]       fill;
  logic [PAT_W-1:0] window;
  logic             match;
  logic [CNT_W-1:0] match_cnt;

  int    n_checks = 0;
  int    n_fail   = 0;
  string scen;
  int    bitno;
  logic [PAT_W-1:0] exp_win;

  always #5 clk = ~clk;

  spi_pattern_fsm #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .i_Clk      (clk),
    .i_Rst      (rst_n),
    .i_Clr      (clr),
    .i_Data_en  (data_en),
    .i_Data     (data),
    .i_Pattern  (pattern),
    .i_Mask     (mask),
    .i_Mode     (mode),
    .o_State    (state),
    .o_State_en (state_en),
    .o_Fill     (fill),
    .o_Window   (window),
    .o_Match    (match),
    .o_Match_cnt(match_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int cnt_exp(input int n);
`ifdef SPI_PATTERN_MATCH_CNT_EN
    return n;
`else
    return 0;
`endif
  endfunction

  task automatic check_zero(input string tag);
    check({tag, " state"},    32'(state),     0);
    check({tag, " fill"},     32'(fill),      0);
    check({tag, " window"},   32'(window),    0);
    check({tag, " match"},    32'(match),     0);
    check({tag, " state_en"}, 32'(state_en),  0);
    check({tag, " cnt"},      32'(match_cnt), 0);
  endtask

  // Drive one qualified bit and check the status produced by it.
  task automatic send_bit(input logic b, input int ef, input int es, input int em);
    @(negedge clk);
    data_en = 1'b1;
    data    = b;
    @(posedge clk);
    #1;
    data_en = 1'b0;
    bitno++;
    exp_win = {exp_win[PAT_W-2:0], b};
    check($sformatf("%s b%0d fill", scen, bitno),     32'(fill),     32'(ef));
    check($sformatf("%s b%0d state", scen, bitno),    32'(state),    32'(es));
    check($sformatf("%s b%0d match", scen, bitno),    32'(match),    32'(em));
    check($sformatf("%s b%0d state_en", scen, bitno), 32'(state_en), 1);
    check($sformatf("%s b%0d window", scen, bitno),   32'(window),   32'(exp_win));
  endtask

  task automatic idle_cycle(input int es);
    @(posedge clk);
    #1;
    check({scen, " idle state_en"}, 32'(state_en), 0);
    check({scen, " idle match"},    32'(match),    0);
    check({scen, " idle state"},    32'(state),    32'(es));
  endtask

  task automatic do_clear();
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    bitno   = 0;
    exp_win = '0;
    check_zero({scen, " clr"});
  endtask

  initial begin
    rst_n   = 1'b0;
    clr     = 1'b0;
    data_en = 1'b0;
    data    = 1'b0;
    pattern = 4'b1011;
    mask    = 4'hF;
    mode    = 1'b0;
    bitno   = 0;
    exp_win = '0;

    scen = "reset";
    #8  check_zero("reset t8");
    #10 check_zero("reset t18");
    #4  rst_n = 1'b1;

    // Overlapping: matches on bits 4 and 7.
    scen = "ovl";
    send_bit(1, 1, 1, 0);
    send_bit(0, 2, 1, 0);
    send_bit(1, 3, 1, 0);
    send_bit(1, 4, 3, 1);
    send_bit(0, 4, 2, 0);
    send_bit(1, 4, 2, 0);
    send_bit(1, 4, 3, 1);
    idle_cycle(3);
    check("ovl cnt", 32'(match_cnt), 32'(cnt_exp(2)));

    // Non-overlapping: one match, fill forced to 0, then refill.
    scen = "novl";
    do_clear();
    mode = 1'b1;
    send_bit(1, 1, 1, 0);
    send_bit(0, 2, 1, 0);
    send_bit(1, 3, 1, 0);
    send_bit(1, 0, 3, 1);
    send_bit(0, 1, 1, 0);
    send_bit(1, 2, 1, 0);
    send_bit(1, 3, 1, 0);
    check("novl cnt", 32'(match_cnt), 32'(cnt_exp(1)));

    // Mask 1001 / pattern 1001: only the outer bits are compared.
    scen = "mask";
    do_clear();
    mode    = 1'b0;
    mask    = 4'b1001;
    pattern = 4'b1001;
    send_bit(1, 1, 1, 0);
    send_bit(1, 2, 1, 0);
    send_bit(0, 3, 1, 0);
    send_bit(1, 4, 3, 1);   // 1101
    send_bit(0, 4, 2, 0);   // 1010
    send_bit(1, 4, 2, 0);   // 0101
    send_bit(1, 4, 3, 1);   // 1011
    send_bit(0, 4, 2, 0);   // 0110
    send_bit(1, 4, 3, 1);   // 1101
    check("mask cnt", 32'(match_cnt), 32'(cnt_exp(3)));

    // Clear colliding with a data strobe.
    scen = "coll";
    do_clear();
    mask    = 4'hF;
    pattern = 4'b1011;
    send_bit(1, 1, 1, 0);
    send_bit(0, 2, 1, 0);
    send_bit(1, 3, 1, 0);
    @(negedge clk);
    clr     = 1'b1;
    data_en = 1'b1;
    data    = 1'b1;
    @(posedge clk);
    #1;
    clr     = 1'b0;
    data_en = 1'b0;
    bitno   = 0;
    exp_win = '0;
    check_zero("coll");
    send_bit(1, 1, 1, 0);

    // Saturation with mask 0: four matches on a 2-bit counter.
    scen = "sat";
    do_clear();
    mask = 4'h0;
    send_bit(1, 1, 1, 0);
    send_bit(0, 2, 1, 0);
    send_bit(1, 3, 1, 0);
    send_bit(0, 4, 3, 1);
    send_bit(1, 4, 3, 1);
    send_bit(0, 4, 3, 1);
    check("sat cnt3", 32'(match_cnt), 32'(cnt_exp(3)));
    send_bit(1, 4, 3, 1);
    check("sat hold", 32'(match_cnt), 32'(cnt_exp(3)));

    // Asynchronous reset between edges, with a strobe pending.
    scen = "arst";
    @(negedge clk);
    data_en = 1'b1;
    data    = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_zero("arst now");
    data_en = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("arst release state_en", 32'(state_en), 0);
    check("arst release state",    32'(state),    0);
    bitno   = 0;
    exp_win = '0;
    send_bit(1, 1, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
